// File: rtl/key_event_sched.sv
// Turns the debounced 16-key level vector into a queue of press/release events for the CPU.
// Simultaneous changes are served one per clock in round-robin order; unreported bounces merge.
module key_event_sched #(
   parameter int DEPTH = 4,
   parameter int CW    = 3
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic          enable,
   input  logic          irq_en,
   input  logic [15:0]   key_deb,
   input  logic          rd_en,
   output logic          evt_valid,
   output logic          evt_press,
   output logic [3:0]    evt_code,
   output logic [CW-1:0] evt_count,
   output logic          busy,
   output logic          irq
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [15:0]   rpt_q, rpt_d;
   logic [3:0]    ptr_q, ptr_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic [4:0]    mem_q [DEPTH];

   logic [15:0] pend;
   logic [3:0]  grant_idx;
   logic [3:0]  idx;
   logic        found;
   logic        full;
   logic        push;
   logic        pop;

   assign pend = key_deb ^ rpt_q;
   assign full = (count_q == CW'(DEPTH));

   // First pending key at or after ptr, wrapping modulo 16.
   always_comb begin
      found     = 1'b0;
      grant_idx = 4'd0;
      idx       = 4'd0;
      for (int i = 0; i < 16; i++) begin
         idx = ptr_q + 4'(i);
         if (!found && pend[idx]) begin
            found     = 1'b1;
            grant_idx = idx;
         end
      end
   end

   assign push = enable & found & ~full;
   assign pop  = rd_en & evt_valid;

   always_comb begin
      rpt_d    = rpt_q;
      ptr_d    = ptr_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q + CW'(push) - CW'(pop);
      // While disabled, keys are tracked silently so re-enable only reports new changes.
      if (!enable) begin
         rpt_d = key_deb;
      end else if (push) begin
         rpt_d[grant_idx] = key_deb[grant_idx];
         ptr_d            = grant_idx + 4'd1;
      end
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         rpt_q    <= '0;
         ptr_q    <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rpt_q    <= rpt_d;
         ptr_q    <= ptr_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: the head is masked by evt_valid.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= {key_deb[grant_idx], grant_idx};
   end

   assign evt_valid = (count_q != '0);
   assign evt_press = evt_valid ? mem_q[rd_ptr_q][4]   : 1'b0;
   assign evt_code  = evt_valid ? mem_q[rd_ptr_q][3:0] : 4'd0;
   assign evt_count = count_q;
   // Gated by rstn so every output reads 0 while reset is held.
   assign busy      = rstn & enable & (|pend);
   assign irq       = evt_valid & irq_en;

endmodule

// File: doc/key_event_sched.md
Name: key_event_sched

Overview:
- Converts the debounced 16-key level vector from the keyboard debounce stage into a serialized stream of press/release events for the CPU.
- Keys changing together are granted one event per clock by a round-robin arbiter and written into a small event FIFO.
- The CPU-side register wrapper pops the FIFO; a level interrupt is raised while events are pending.
- Coalesces bounces the debouncer lets through, so an event is never lost, only merged.

Parameters:
- DEPTH, 4, event FIFO depth in entries; power of two, 2..16.
- CW, 3, count width; must satisfy 2^CW > DEPTH.

Ports:
- clk  input  1  system clock.
- rstn  input  1  asynchronous active-low reset.
- enable  input  1  1 = generate events; 0 = track keys silently.
- irq_en  input  1  interrupt mask.
- key_deb  input  16  debounced key levels, 1 = pressed, synchronous to clk.
- rd_en  input  1  pop the head event; ignored when empty.
- evt_valid  output  1  FIFO not empty.
- evt_press  output  1  head event type: 1 = press, 0 = release.
- evt_code  output  4  head event key index.
- evt_count  output  CW  number of entries in the FIFO.
- busy  output  1  at least one key change is not yet reported.
- irq  output  1  evt_valid AND irq_en.

Behaviour:
- Reset values:
  - rpt[15:0] = 0 (last reported level per key).
  - ptr[3:0] = 0.
  - FIFO empty: evt_count = 0, evt_valid = 0.
  - evt_press = 0, evt_code = 0, busy = 0, irq = 0.
- Pending mask: pend = key_deb XOR rpt (combinational); busy = |pend AND enable.
- Arbiter search order: ptr, ptr+1, … wrapping modulo 16. The first set pend bit found is the candidate index g.
- Grant: occurs when enable = 1, pend != 0 and evt_count != DEPTH (registered count, before any same-cycle pop). On a grant at a clk edge:
  - Push {key_deb[g], g} into the FIFO.
  - rpt[g] <= key_deb[g].
  - ptr <= g+1 mod 16.
  - At most one push per cycle.
- No grant: rpt and ptr hold. Pending changes wait; they are never dropped.
- Coalescing: a key that toggles 1->0->1 before it is granted produces no event, because pend returns to 0. A key that changes again after its grant produces a new event.
- enable = 0: rpt <= key_deb every cycle and no pushes occur. FIFO contents stay readable and poppable. When enable returns to 1, only changes after the re-enable edge generate events.
- Latency: if key_deb changes before edge k, the FIFO is not full and the key wins arbitration, evt_valid/evt_press/evt_code show the event after edge k (one cycle).
- FIFO:
  - Circular buffer with write and read pointers.
  - Outputs are driven combinationally from the head entry; evt_press and evt_code are 0 when empty.
  - Pop occurs on rd_en = 1 while evt_valid = 1; rd_en while empty has no effect.
  - Push and pop in the same cycle: count unchanged.
  - When full, push is blocked even if pop is asserted that cycle; the push occurs the following cycle.
  - Pointers wrap modulo DEPTH. evt_count saturates neither above DEPTH nor below 0.
- irq: combinational level from evt_valid and irq_en; no edge detection.
- Reset mid-operation: all state returns to reset values immediately. Keys held across reset then appear as pending presses, since rpt = 0.

Test Plan:
- Single key: after reset, key_deb = 0x0010 -> one cycle later evt_valid = 1, evt_press = 1, evt_code = 4, evt_count = 1. Pop with rd_en, then key_deb = 0 -> release event with code 4.
- Round-robin order: key_deb 0 -> 0x8101 in one cycle, ptr = 0 -> events pushed on three consecutive edges, codes 0, 8, 15; ptr ends at 0. Repeat with ptr = 9 -> order 15, 0, 8.
- Full stall with DEPTH = 4: six simultaneous presses (0x003F), no reads -> evt_count = 4, busy = 1. Issue one pop -> the next event (code 4) is pushed on the following edge. All six events are eventually delivered in order.
- Coalescing: key 3 glitches 0->1->0 within one cycle while the FIFO is full -> no event for key 3 after draining.
- Enable and irq: enable = 0 while key_deb = 0x0002 -> no event, busy = 0. Set enable = 1, then key_deb = 0 -> a release event for code 1 only. irq follows evt_valid only when irq_en = 1.
- Simultaneous push and pop at evt_count = 2 -> count stays 2 and the head advances. Assert rstn low mid-stream with key_deb = 0x0001 -> all outputs 0; after release, a press event for code 0 is generated.
